// File: rtl/food_spawner.sv
// Multi-item food manager: detects head/food collisions, keeps a saturating score,
// and respawns eaten items at free cells using an LFSR with a linear-scan fallback.
module food_spawner #(
  parameter int          GRID_W    = 32,
  parameter int          GRID_H    = 24,
  parameter int          CELL      = 20,
  parameter int          NUM_FOOD  = 2,
  parameter int          POINTS    = 1,
  parameter int          SCORE_W   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        endgame,
  input  logic                        step,
  input  logic [9:0]                  headx,
  input  logic [9:0]                  heady,
  output logic                        occ_req,
  output logic [$clog2(GRID_W)-1:0]   occ_cx,
  output logic [$clog2(GRID_H)-1:0]   occ_cy,
  input  logic                        occ_hit,
  output logic [10*NUM_FOOD-1:0]      food_x,
  output logic [10*NUM_FOOD-1:0]      food_y,
  output logic [NUM_FOOD-1:0]         food_valid,
  output logic                        eat,
  output logic [SCORE_W-1:0]          score,
  output logic                        busy,
  output logic                        full,
  output logic [1:0]                  dbg_state
);
  localparam int CXW = $clog2(GRID_W);
  localparam int CYW = $clog2(GRID_H);
  localparam int IW  = (NUM_FOOD > 1) ? $clog2(NUM_FOOD) : 1;
  localparam int TW  = $clog2(MAX_TRIES + 1);
  localparam int SW  = $clog2(GRID_W * GRID_H + 1);
  localparam logic [9:0]       INIT_Y = 10'((GRID_H / 2) * CELL);
  localparam logic [SCORE_W:0] SMAX   = {1'b0, {SCORE_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_PICK, S_QUERY, S_CHECK} state_t;

  function automatic logic [9:0] init_x(input int i);
    return 10'((4 + 4 * i) * CELL);
  endfunction

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q;
  logic [9:0]          fx_q [NUM_FOOD];
  logic [9:0]          fx_d [NUM_FOOD];
  logic [9:0]          fy_q [NUM_FOOD];
  logic [9:0]          fy_d [NUM_FOOD];
  logic [NUM_FOOD-1:0] fv_q, fv_d, pend_q, pend_d;
  logic [IW-1:0]       sel_q, sel_d;
  logic [TW-1:0]       tries_q, tries_d;
  logic                scan_q, scan_d;
  logic [SW-1:0]       scnt_q, scnt_d;
  logic [CXW-1:0]      cand_cx_q, cand_cx_d, head_cx_q, head_cx_d, next_cx;
  logic [CYW-1:0]      cand_cy_q, cand_cy_d, head_cy_q, head_cy_d, next_cy;
  logic                eat_q, eat_d, full_q, full_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W:0]    score_sum;
  logic                hit_any, food_clash, head_clash;
  logic [IW-1:0]       hit_idx, low_idx;
  logic [9:0]          cand_px, cand_py;

  // Galois LFSR free-runs outside reset; endgame deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  assign cand_px    = 10'(32'(cand_cx_q) * CELL);
  assign cand_py    = 10'(32'(cand_cy_q) * CELL);
  assign head_clash = (cand_cx_q == head_cx_q) && (cand_cy_q == head_cy_q);
  assign score_sum  = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);

  always_comb begin
    next_cx = cand_cx_q + 1'b1;
    next_cy = cand_cy_q;
    if (cand_cx_q == CXW'(GRID_W - 1)) begin
      next_cx = '0;
      next_cy = (cand_cy_q == CYW'(GRID_H - 1)) ? '0 : cand_cy_q + 1'b1;
    end
  end

  // Descending loops so the lowest matching index wins.
  always_comb begin
    hit_any    = 1'b0;
    hit_idx    = '0;
    low_idx    = '0;
    food_clash = 1'b0;
    for (int i = NUM_FOOD - 1; i >= 0; i--) begin
      if (fv_q[i] && headx == fx_q[i] && heady == fy_q[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
      if (pend_q[i]) low_idx = IW'(i);
      if (fv_q[i] && fx_q[i] == cand_px && fy_q[i] == cand_py) food_clash = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    fx_d      = fx_q;
    fy_d      = fy_q;
    fv_d      = fv_q;
    pend_d    = pend_q;
    sel_d     = sel_q;
    tries_d   = tries_q;
    scan_d    = scan_q;
    scnt_d    = scnt_q;
    cand_cx_d = cand_cx_q;
    cand_cy_d = cand_cy_q;
    head_cx_d = head_cx_q;
    head_cy_d = head_cy_q;
    eat_d     = 1'b0;
    score_d   = score_q;
    full_d    = full_q;

    if (step) begin
      head_cx_d = CXW'(32'(headx) / CELL);
      head_cy_d = CYW'(32'(heady) / CELL);
      if (hit_any) begin
        fv_d[hit_idx]   = 1'b0;
        pend_d[hit_idx] = 1'b1;
        eat_d           = 1'b1;
        score_d         = (score_sum > SMAX) ? SMAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          sel_d   = low_idx;
          tries_d = '0;
          scan_d  = 1'b0;
          scnt_d  = '0;
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        if (scan_q) begin
          cand_cx_d = next_cx;
          cand_cy_d = next_cy;
        end else begin
          cand_cx_d = CXW'(32'(lfsr_q[7:0]) % GRID_W);
          cand_cy_d = CYW'(32'(lfsr_q[15:8]) % GRID_H);
        end
        state_d = S_QUERY;
      end
      S_QUERY: state_d = S_CHECK;
      S_CHECK: begin
        if (!occ_hit && !head_clash && !food_clash) begin
          fx_d[sel_q]   = cand_px;
          fy_d[sel_q]   = cand_py;
          fv_d[sel_q]   = 1'b1;
          pend_d[sel_q] = 1'b0;
          state_d       = S_IDLE;
        end else if (!scan_q) begin
          tries_d = tries_q + 1'b1;
          if (tries_q == TW'(MAX_TRIES - 1)) scan_d = 1'b1;
          state_d = S_PICK;
        end else if (scnt_q == SW'(GRID_W * GRID_H - 1)) begin
          full_d        = 1'b1;
          pend_d[sel_q] = 1'b0;
          state_d       = S_IDLE;
        end else begin
          scnt_d  = scnt_q + 1'b1;
          state_d = S_PICK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (endgame) begin
      state_d = S_IDLE;
      for (int i = 0; i < NUM_FOOD; i++) begin
        fx_d[i] = init_x(i);
        fy_d[i] = INIT_Y;
      end
      fv_d    = '1;
      pend_d  = '0;
      eat_d   = 1'b0;
      score_d = '0;
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NUM_FOOD; i++) begin
        fx_q[i] <= init_x(i);
        fy_q[i] <= INIT_Y;
      end
      fv_q      <= '1;
      pend_q    <= '0;
      sel_q     <= '0;
      tries_q   <= '0;
      scan_q    <= 1'b0;
      scnt_q    <= '0;
      cand_cx_q <= '0;
      cand_cy_q <= '0;
      head_cx_q <= '0;
      head_cy_q <= '0;
      eat_q     <= 1'b0;
      score_q   <= '0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fx_q      <= fx_d;
      fy_q      <= fy_d;
      fv_q      <= fv_d;
      pend_q    <= pend_d;
      sel_q     <= sel_d;
      tries_q   <= tries_d;
      scan_q    <= scan_d;
      scnt_q    <= scnt_d;
      cand_cx_q <= cand_cx_d;
      cand_cy_q <= cand_cy_d;
      head_cx_q <= head_cx_d;
      head_cy_q <= head_cy_d;
      eat_q     <= eat_d;
      score_q   <= score_d;
      full_q    <= full_d;
    end
  end

  always_comb begin
    food_x = '0;
    food_y = '0;
    for (int i = 0; i < NUM_FOOD; i++) begin
      food_x[10*i +: 10] = fx_q[i];
      food_y[10*i +: 10] = fy_q[i];
    end
  end

  assign food_valid = fv_q;
  assign occ_req    = (state_q == S_QUERY);
  assign occ_cx     = cand_cx_q;
  assign occ_cy     = cand_cy_q;
  assign eat        = eat_q;
  assign score      = score_q;
  assign busy       = (state_q != S_IDLE);
  assign full       = full_q;
  assign dbg_state  = state_q;
endmodule
